// File: rtl/axil2apb.sv
// AXI4-Lite slave to APB3 master bridge: one buffered write and one buffered read,
// serialized onto APB with round-robin arbitration; APB errors and timeouts become SLVERR.
module axil2apb #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        s_axil_awvalid,
    output logic        s_axil_awready,
    input  logic [31:0] s_axil_awaddr,
    input  logic        s_axil_wvalid,
    output logic        s_axil_wready,
    input  logic [31:0] s_axil_wdata,
    input  logic [3:0]  s_axil_wstrb,
    output logic        s_axil_bvalid,
    input  logic        s_axil_bready,
    output logic [1:0]  s_axil_bresp,
    input  logic        s_axil_arvalid,
    output logic        s_axil_arready,
    input  logic [31:0] s_axil_araddr,
    output logic        s_axil_rvalid,
    input  logic        s_axil_rready,
    output logic [31:0] s_axil_rdata,
    output logic [1:0]  s_axil_rresp,
    output logic [31:0] paddr,
    output logic        psel,
    output logic        penable,
    output logic        pwrite,
    output logic [31:0] pwdata,
    input  logic [31:0] prdata,
    input  logic        pready,
    input  logic        pslverr
);

    typedef enum logic [2:0] {IDLE, SETUP, ACCESS, WRESP, RRESP} state_t;

    // Last ACCESS cycle index before a forced termination (counter starts at 0).
    localparam logic [15:0] TO_LAST = (TIMEOUT == 0) ? 16'd0 : 16'(TIMEOUT - 1);

    state_t      state, state_next;
    logic        aw_full, w_full, ar_full;
    logic [31:0] awaddr_q, wdata_q, araddr_q;
    logic [3:0]  wstrb_q;
    logic        last_grant_rd;
    logic [15:0] tcnt;
    logic        wr_rdy, rd_rdy, grant_wr, grant_rd, timeout_hit, b_hs, r_hs;

    assign s_axil_awready = !aw_full;
    assign s_axil_wready  = !w_full;
    assign s_axil_arready = !ar_full;

    assign wr_rdy      = aw_full & w_full;
    assign rd_rdy      = ar_full;
    assign grant_wr    = wr_rdy & (!rd_rdy | last_grant_rd);
    assign grant_rd    = rd_rdy & (!wr_rdy | !last_grant_rd);
    assign timeout_hit = (TIMEOUT != 0) && (tcnt == TO_LAST) && !pready;
    assign b_hs        = s_axil_bvalid & s_axil_bready;
    assign r_hs        = s_axil_rvalid & s_axil_rready;

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                // Partial-strobe writes are refused without touching APB.
                if (grant_wr)
                    state_next = (wstrb_q == 4'hF) ? SETUP : WRESP;
                else if (grant_rd)
                    state_next = SETUP;
            end
            SETUP:   state_next = ACCESS;
            ACCESS:  if (pready || timeout_hit) state_next = pwrite ? WRESP : RRESP;
            WRESP:   if (s_axil_bready) state_next = IDLE;
            RRESP:   if (s_axil_rready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state         <= IDLE;
            aw_full       <= 1'b0;
            w_full        <= 1'b0;
            ar_full       <= 1'b0;
            awaddr_q      <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            araddr_q      <= '0;
            last_grant_rd <= 1'b1;
            tcnt          <= '0;
            psel          <= 1'b0;
            penable       <= 1'b0;
            pwrite        <= 1'b0;
            paddr         <= '0;
            pwdata        <= '0;
            s_axil_bvalid <= 1'b0;
            s_axil_bresp  <= 2'b00;
            s_axil_rvalid <= 1'b0;
            s_axil_rresp  <= 2'b00;
            s_axil_rdata  <= '0;
        end else begin
            state <= state_next;

            if (s_axil_awvalid && !aw_full) begin
                aw_full  <= 1'b1;
                awaddr_q <= s_axil_awaddr;
            end else if (b_hs) begin
                aw_full <= 1'b0;
            end
            if (s_axil_wvalid && !w_full) begin
                w_full  <= 1'b1;
                wdata_q <= s_axil_wdata;
                wstrb_q <= s_axil_wstrb;
            end else if (b_hs) begin
                w_full <= 1'b0;
            end
            if (s_axil_arvalid && !ar_full) begin
                ar_full  <= 1'b1;
                araddr_q <= s_axil_araddr;
            end else if (r_hs) begin
                ar_full <= 1'b0;
            end

            psel          <= (state_next == SETUP) || (state_next == ACCESS);
            penable       <= (state_next == ACCESS);
            s_axil_bvalid <= (state_next == WRESP);
            s_axil_rvalid <= (state_next == RRESP);

            if (state == IDLE && grant_wr) begin
                last_grant_rd <= 1'b0;
                if (wstrb_q != 4'hF) begin
                    s_axil_bresp <= 2'b10;
                end else begin
                    paddr  <= awaddr_q;
                    pwrite <= 1'b1;
                    pwdata <= wdata_q;
                end
            end else if (state == IDLE && grant_rd) begin
                last_grant_rd <= 1'b1;
                paddr         <= araddr_q;
                pwrite        <= 1'b0;
            end

            if (state_next == SETUP)
                tcnt <= '0;
            else if (state == ACCESS)
                tcnt <= tcnt + 16'd1;

            // A timed-out transfer reports SLVERR and returns zero read data.
            if (state == ACCESS && (pready || timeout_hit)) begin
                if (pwrite) begin
                    s_axil_bresp <= (pready && !pslverr) ? 2'b00 : 2'b10;
                end else begin
                    s_axil_rresp <= (pready && !pslverr) ? 2'b00 : 2'b10;
                    s_axil_rdata <= pready ? prdata : 32'h0;
                end
            end
        end
    end

endmodule

// File: tb/tb_axil2apb.sv
// Self-checking bench for axil2apb: vector table plus hand sequences, with an APB responder
// and scoreboard queues for APB transfers, B responses and R responses.
module tb_axil2apb;

    logic        clk, rstn;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic [31:0] paddr, pwdata, prdata;
    logic        psel, penable, pwrite, pready, pslverr;

    axil2apb #(.TIMEOUT(4)) dut (
        .clk(clk), .rstn(rstn),
        .s_axil_awvalid(awvalid), .s_axil_awready(awready), .s_axil_awaddr(awaddr),
        .s_axil_wvalid(wvalid), .s_axil_wready(wready), .s_axil_wdata(wdata), .s_axil_wstrb(wstrb),
        .s_axil_bvalid(bvalid), .s_axil_bready(bready), .s_axil_bresp(bresp),
        .s_axil_arvalid(arvalid), .s_axil_arready(arready), .s_axil_araddr(araddr),
        .s_axil_rvalid(rvalid), .s_axil_rready(rready), .s_axil_rdata(rdata), .s_axil_rresp(rresp),
        .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    typedef struct {
        bit          do_wr;
        logic [31:0] waddr;
        logic [31:0] wdat;
        logic [3:0]  wstb;
        bit          do_rd;
        logic [31:0] raddr;
        int          wait_cycles;
        bit          err;
        logic [31:0] rd_val;
        logic [1:0]  exp_bresp;
        logic [1:0]  exp_rresp;
        logic [31:0] exp_rdata;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] data;
    } apb_t;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
    } rsp_t;

    apb_t        exp_apb[$];
    logic [1:0]  exp_b[$];
    rsp_t        exp_r[$];

    int          errors = 0;
    int          checks = 0;
    int          apb_wait = 0;
    bit          apb_err = 0;
    logic [31:0] apb_rdata = 0;
    int          acc_cnt = 0;
    int          access_len = 0;
    bit          prev_access = 0;
    bit          last_is_read = 1;
    vec_t        vecs[10];

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic expectWrite(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                               input logic [1:0] resp);
        apb_t t;
        if (s == 4'hF) begin
            t.addr = a; t.wr = 1'b1; t.data = d;
            exp_apb.push_back(t);
        end
        exp_b.push_back(resp);
        last_is_read = 0;
    endtask

    task automatic expectRead(input logic [31:0] a, input logic [31:0] d, input logic [1:0] resp);
        apb_t t;
        rsp_t r;
        t.addr = a; t.wr = 1'b0; t.data = '0;
        exp_apb.push_back(t);
        r.data = d; r.resp = resp;
        exp_r.push_back(r);
        last_is_read = 1;
    endtask

    // Pushes expectations in the grant order the bridge should choose, then handshakes.
    task automatic applyStimulus(input vec_t v);
        bit hs_aw, hs_w, hs_ar;
        apb_wait = v.wait_cycles;
        apb_err = v.err;
        apb_rdata = v.rd_val;
        if (v.do_wr && v.do_rd && !last_is_read) begin
            expectRead(v.raddr, v.exp_rdata, v.exp_rresp);
            expectWrite(v.waddr, v.wdat, v.wstb, v.exp_bresp);
        end else begin
            if (v.do_wr) expectWrite(v.waddr, v.wdat, v.wstb, v.exp_bresp);
            if (v.do_rd) expectRead(v.raddr, v.exp_rdata, v.exp_rresp);
        end
        @(negedge clk);
        awvalid = v.do_wr; awaddr = v.waddr;
        wvalid = v.do_wr; wdata = v.wdat; wstrb = v.wstb;
        arvalid = v.do_rd; araddr = v.raddr;
        for (int n = 0; n < 50 && (awvalid || wvalid || arvalid); n++) begin
            hs_aw = awvalid && awready;
            hs_w = wvalid && wready;
            hs_ar = arvalid && arready;
            @(negedge clk);
            if (hs_aw) awvalid = 0;
            if (hs_w) wvalid = 0;
            if (hs_ar) arvalid = 0;
        end
        checkOutput("axi_handshake", 32'({awvalid, wvalid, arvalid}), 32'h0);
        awvalid = 0; wvalid = 0; arvalid = 0;
    endtask

    task automatic waitDrained();
        int n;
        for (n = 0; n < 200 && (exp_b.size() + exp_r.size() + exp_apb.size()) != 0; n++)
            @(negedge clk);
        checkOutput("drain_pending", 32'(exp_b.size() + exp_r.size() + exp_apb.size()), 32'h0);
    endtask

    // APB responder and scoreboard monitor, sampled just after the falling edge.
    initial begin
        logic [1:0] eb;
        rsp_t er;
        pready = 0; prdata = 0; pslverr = 0;
        forever begin
            @(negedge clk);
            #1;
            if (psel && penable) begin
                pready = (acc_cnt == apb_wait);
                prdata = pready ? apb_rdata : $urandom;
                pslverr = apb_err;
                acc_cnt++;
            end else begin
                pready = 0;
                pslverr = 0;
                if (prev_access) begin
                    access_len = acc_cnt;
                    if (exp_apb.size() > 0) void'(exp_apb.pop_front());
                end
                acc_cnt = 0;
            end
            prev_access = psel && penable;
            if (psel) begin
                if (exp_apb.size() == 0) begin
                    checkOutput("unexpected_psel", 32'(psel), 32'h0);
                end else begin
                    checkOutput("paddr", paddr, exp_apb[0].addr);
                    checkOutput("pwrite", 32'(pwrite), 32'(exp_apb[0].wr));
                    if (exp_apb[0].wr) checkOutput("pwdata", pwdata, exp_apb[0].data);
                end
            end
            if (bvalid && bready) begin
                if (exp_b.size() == 0) begin
                    checkOutput("unexpected_bvalid", 32'(bvalid), 32'h0);
                end else begin
                    eb = exp_b.pop_front();
                    checkOutput("bresp", 32'(bresp), 32'(eb));
                end
            end
            if (rvalid && rready) begin
                if (exp_r.size() == 0) begin
                    checkOutput("unexpected_rvalid", 32'(rvalid), 32'h0);
                end else begin
                    er = exp_r.pop_front();
                    checkOutput("rdata", rdata, er.data);
                    checkOutput("rresp", 32'(rresp), 32'(er.resp));
                end
            end
        end
    end

    initial begin
        vec_t v;
        int n;
        vecs[0] = '{1, 32'h100, 32'hDEADBEEF, 4'hF, 0, 32'h0,   0,  0, 32'h0,        2'b00, 2'b00, 32'h0};
        vecs[1] = '{0, 32'h0,   32'h0,        4'h0, 1, 32'h204, 3,  1, 32'h12345678, 2'b00, 2'b10, 32'h12345678};
        vecs[2] = '{1, 32'h300, 32'h11112222, 4'hF, 1, 32'h304, 1,  0, 32'hCAFEF00D, 2'b00, 2'b00, 32'hCAFEF00D};
        vecs[3] = '{1, 32'h308, 32'h33334444, 4'hF, 1, 32'h30C, 0,  0, 32'h55AA55AA, 2'b00, 2'b00, 32'h55AA55AA};
        vecs[4] = '{1, 32'h400, 32'h0F0F0F0F, 4'h3, 0, 32'h0,   0,  0, 32'h0,        2'b10, 2'b00, 32'h0};
        vecs[5] = '{0, 32'h0,   32'h0,        4'h0, 1, 32'h500, 99, 0, 32'h77777777, 2'b00, 2'b10, 32'h0};
        vecs[6] = '{1, 32'h600, 32'h66666666, 4'hF, 0, 32'h0,   99, 0, 32'h0,        2'b10, 2'b00, 32'h0};
        vecs[7] = '{1, 32'h700, 32'hFACEB00C, 4'hF, 1, 32'h704, 0,  1, 32'h0BADF00D, 2'b10, 2'b10, 32'h0BADF00D};
        vecs[8] = '{0, 32'h0,   32'h0,        4'h0, 1, 32'h804, 2,  0, 32'h89ABCDEF, 2'b00, 2'b00, 32'h89ABCDEF};
        vecs[9] = '{1, 32'h900, 32'h12121212, 4'h8, 0, 32'h0,   0,  0, 32'h0,        2'b10, 2'b00, 32'h0};

        rstn = 0; awvalid = 0; wvalid = 0; arvalid = 0; bready = 1; rready = 1;
        awaddr = 0; wdata = 0; wstrb = 0; araddr = 0;
        repeat (3) @(negedge clk);
        rstn = 1;

        checkOutput("rst_psel", 32'(psel), 32'h0);
        checkOutput("rst_penable", 32'(penable), 32'h0);
        checkOutput("rst_pwrite", 32'(pwrite), 32'h0);
        checkOutput("rst_paddr", paddr, 32'h0);
        checkOutput("rst_pwdata", pwdata, 32'h0);
        checkOutput("rst_bvalid", 32'(bvalid), 32'h0);
        checkOutput("rst_rvalid", 32'(rvalid), 32'h0);
        checkOutput("rst_bresp", 32'(bresp), 32'h0);
        checkOutput("rst_rresp", 32'(rresp), 32'h0);
        checkOutput("rst_rdata", rdata, 32'h0);
        checkOutput("rst_awready", 32'(awready), 32'h1);
        checkOutput("rst_wready", 32'(wready), 32'h1);
        checkOutput("rst_arready", 32'(arready), 32'h1);

        $display("[TB] best-case write latency");
        apb_wait = 0; apb_err = 0;
        expectWrite(32'h100, 32'hDEADBEEF, 4'hF, 2'b00);
        @(negedge clk);
        awvalid = 1; awaddr = 32'h100; wvalid = 1; wdata = 32'hDEADBEEF; wstrb = 4'hF;
        @(negedge clk);
        awvalid = 0; wvalid = 0;
        checkOutput("t1_awready_c0", 32'(awready), 32'h0);
        checkOutput("t1_psel_c0", 32'(psel), 32'h0);
        @(negedge clk);
        checkOutput("t1_psel_c1", 32'(psel), 32'h1);
        checkOutput("t1_penable_c1", 32'(penable), 32'h0);
        @(negedge clk);
        checkOutput("t1_penable_c2", 32'(penable), 32'h1);
        checkOutput("t1_pwdata_c2", pwdata, 32'hDEADBEEF);
        @(negedge clk);
        checkOutput("t1_bvalid_c3", 32'(bvalid), 32'h1);
        checkOutput("t1_psel_c3", 32'(psel), 32'h0);
        waitDrained();

        $display("[TB] vector table");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i]);
            waitDrained();
        end

        $display("[TB] W before AW, delayed bready");
        apb_wait = 1; apb_err = 0; bready = 0;
        expectWrite(32'h110, 32'hA5A55A5A, 4'hF, 2'b00);
        @(negedge clk);
        wvalid = 1; wdata = 32'hA5A55A5A; wstrb = 4'hF;
        checkOutput("t3_wready_before", 32'(wready), 32'h1);
        @(negedge clk);
        wvalid = 0;
        for (int i = 0; i < 5; i++) begin
            checkOutput("t3_psel_idle", 32'(psel), 32'h0);
            checkOutput("t3_wready_held", 32'(wready), 32'h0);
            @(negedge clk);
        end
        checkOutput("t3_awready_open", 32'(awready), 32'h1);
        awvalid = 1; awaddr = 32'h110;
        @(negedge clk);
        awvalid = 0;
        for (n = 0; n < 20 && !bvalid; n++) @(negedge clk);
        checkOutput("t3_bvalid_seen", 32'(bvalid), 32'h1);
        for (int i = 0; i < 4; i++) begin
            checkOutput("t3_bvalid_stable", 32'(bvalid), 32'h1);
            checkOutput("t3_bresp_stable", 32'(bresp), 32'h0);
            checkOutput("t3_awready_busy", 32'(awready), 32'h0);
            checkOutput("t3_wready_busy", 32'(wready), 32'h0);
            @(negedge clk);
        end
        bready = 1;
        @(negedge clk);
        checkOutput("t3_bvalid_done", 32'(bvalid), 32'h0);
        checkOutput("t3_awready_back", 32'(awready), 32'h1);
        checkOutput("t3_wready_back", 32'(wready), 32'h1);
        waitDrained();

        $display("[TB] read timeout");
        v = '{0, 32'h0, 32'h0, 4'h0, 1, 32'hA40, 99, 0, 32'h0, 2'b00, 2'b10, 32'h0};
        applyStimulus(v);
        waitDrained();
        checkOutput("t6_access_cycles", 32'(access_len), 32'd4);

        $display("[TB] reset during ACCESS with a read buffered");
        v = '{1, 32'hA00, 32'hAAAA0000, 4'hF, 1, 32'hA04, 99, 0, 32'h0, 2'b10, 2'b10, 32'h0};
        applyStimulus(v);
        for (n = 0; n < 20 && !(psel && penable); n++) @(negedge clk);
        checkOutput("t6_reached_access", 32'(psel && penable), 32'h1);
        rstn = 0;
        @(negedge clk);
        exp_apb.delete(); exp_b.delete(); exp_r.delete();
        last_is_read = 1;
        checkOutput("t6_rst_psel", 32'(psel), 32'h0);
        checkOutput("t6_rst_penable", 32'(penable), 32'h0);
        checkOutput("t6_rst_bvalid", 32'(bvalid), 32'h0);
        checkOutput("t6_rst_rvalid", 32'(rvalid), 32'h0);
        checkOutput("t6_rst_arready", 32'(arready), 32'h1);
        rstn = 1;
        repeat (10) @(negedge clk);
        v = '{1, 32'hB00, 32'h0B00B000, 4'hF, 0, 32'h0, 0, 0, 32'h0, 2'b00, 2'b00, 32'h0};
        applyStimulus(v);
        waitDrained();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axil2apb.md
Name: axil2apb

Overview:
AXI4-Lite slave to APB (APB3) master bridge. It is the counterpart to the APB-to-AXI-Lite adapter in the sockets/adapters tree. It lets an AXI-Lite initiator, such as a processor peripheral port, reach APB-only register banks. At most one write and one read are buffered at a time, and APB transfers are serialized with round-robin read/write arbitration. APB errors and timeouts are mapped to SLVERR.

Parameters:
TIMEOUT, 1024, max ACCESS-phase cycles waiting for pready before forced SLVERR termination; 0 disables the timeout; range 0..65535.

Ports:
clk  in  1  clock
rstn  in  1  reset, synchronous, active-low
s_axil_awvalid  in  1  write address valid
s_axil_awready  out  1  write address ready
s_axil_awaddr  in  32  write address
s_axil_wvalid  in  1  write data valid
s_axil_wready  out  1  write data ready
s_axil_wdata  in  32  write data
s_axil_wstrb  in  4  byte strobes
s_axil_bvalid  out  1  write response valid
s_axil_bready  in  1  write response ready
s_axil_bresp  out  2  write response
s_axil_arvalid  in  1  read address valid
s_axil_arready  out  1  read address ready
s_axil_araddr  in  32  read address
s_axil_rvalid  out  1  read data valid
s_axil_rready  in  1  read data ready
s_axil_rdata  out  32  read data
s_axil_rresp  out  2  read response
paddr  out  32  APB address
psel  out  1  APB select
penable  out  1  APB enable
pwrite  out  1  APB direction
pwdata  out  32  APB write data
prdata  in  32  APB read data
pready  in  1  APB ready
pslverr  in  1  APB slave error

Behaviour:
Capture registers:
- aw_full/awaddr_q, w_full/wdata_q/wstrb_q and ar_full/araddr_q.
- awready = !aw_full, wready = !w_full, arready = !ar_full.
- A handshake sets the flag and latches the payload. AW and W are accepted independently in either order, or in the same cycle.

Flag clearing:
- aw_full and w_full clear in the cycle after the B handshake (bvalid & bready).
- ar_full clears in the cycle after the R handshake.

Arbitration (IDLE only):
- A write is ready when aw_full & w_full; a read is ready when ar_full.
- If both are ready, grant the type not granted last. The last_grant register resets to "read", so write wins first.

State machine:
- States: IDLE, SETUP, ACCESS, WRESP, RRESP.
- IDLE to SETUP on grant. Latch paddr and pwrite, and pwdata for writes.
- Exception: a write with wstrb_q != 4'b1111 goes directly IDLE to WRESP with bresp=2'b10 and issues no APB transfer.
- SETUP: psel=1, penable=0. Always one cycle, then ACCESS.
- ACCESS: psel=1, penable=1, held until pready=1 or timeout.
  - On pready: bresp or rresp = pslverr ? 2'b10 : 2'b00, and rdata_q = prdata for reads.
  - Next state is WRESP or RRESP. psel and penable drop in the next cycle.
- Timeout: a 16-bit counter clears on SETUP entry and increments each ACCESS cycle. When it reaches TIMEOUT with pready=0, the transfer terminates with resp 2'b10 and rdata 0. pready in that same cycle wins over the timeout.
- WRESP: bvalid=1, held stable until bready, then IDLE. RRESP: rvalid=1 with rdata/rresp stable until rready, then IDLE.

Timing and outputs:
- All APB and B/R outputs are registered.
- Best-case write: AW+W handshake at cycle 0, SETUP at 1, ACCESS at 2 with pready=1, bvalid at 3. Reads have the same latency.
- paddr and pwrite hold through ACCESS. pwdata holds for writes.

Reset values:
- psel=0, penable=0, pwrite=0, paddr=0, pwdata=0.
- bvalid=0, rvalid=0, bresp=0, rresp=0, rdata=0.
- All full flags 0, so awready, wready and arready read 1. Handshakes count only on cycles with rstn=1.
- State=IDLE, last_grant=read.

Reset mid-operation:
- Reset during ACCESS or a response drops psel/penable/valids next edge and discards buffered requests.
- Any in-flight APB transfer is abandoned; the APB side must tolerate this.

Other rules:
- New AW/W/AR may be accepted while another transfer is in progress, e.g. AR accepted during a write. This is limited to one of each type.
- pwrite=0 and pwdata is don't-care during reads.

Test Plan:
1. Same-cycle AW=0x100/W=0xDEADBEEF/wstrb=F, pready=1 in first ACCESS -> psel at cycle 1, penable at 2, paddr=0x100, pwdata=0xDEADBEEF, bvalid at 3, bresp=00.
2. AR=0x204, APB holds pready low 3 ACCESS cycles then prdata=0x12345678, pslverr=1 -> paddr/psel/penable stable throughout, rvalid with rdata=0x12345678, rresp=10.
3. W then AW 5 cycles later, with bready low 4 cycles -> no APB activity until AW is captured; bvalid/bresp stable until bready; awready/wready return to 1 only after the B handshake.
4. Write and read both pending in IDLE after reset -> write first, then read; repeat with both pending -> write first again, since last_grant is now read.
5. wstrb=4'b0011 -> psel never asserts, bresp=10.
6. TIMEOUT=4, pready tied low -> exactly 4 ACCESS cycles, then rresp=10, rdata=0. Assert rstn=0 mid-ACCESS in a second run -> psel=0, bvalid=0, rvalid=0 next cycle.
